// File: rtl/interval_histogram_mon.sv
// interval_histogram_mon: measures cycles between consecutive event strobes and
// bins each interval into a saturating histogram for register-block readback.
`default_nettype none

module interval_histogram_mon #(
  parameter int CNT_RANGE     = 8,
  parameter int CNT_SIZE      = 16,
  parameter int MAX_CYCLE_CNT = 128
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic                                          clear,
  input  logic                                          freeze,
  input  logic                                          event_strobe,
  output logic [15:0]                                   cycle_cnt,
  output logic [(MAX_CYCLE_CNT/CNT_RANGE)*CNT_SIZE-1:0] mon_cnts,
  output logic [15:0]                                   event_cnt,
  output logic                                          hist_sat,
  output logic                                          busy
);

  localparam int NUM_BINS = MAX_CYCLE_CNT / CNT_RANGE;
  localparam int SHIFT    = $clog2(CNT_RANGE);
  localparam int IDX_W    = $clog2(NUM_BINS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          ivl_q, ivl_d;
  logic [15:0]          cycle_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 valid_q;
  logic [CNT_SIZE-1:0]  bin_q [NUM_BINS];
  logic [15:0]          event_cnt_q;
  logic                 hist_sat_q;

  logic                 ev_seen;
  logic                 capture;
  logic [15:0]          shifted;
  logic [IDX_W-1:0]     bin_idx;
  logic [CNT_SIZE-1:0]  bin_cur;
  logic [CNT_SIZE-1:0]  bin_next;

  assign ev_seen = event_strobe && ((state_q == ARMED) || (state_q == MEASURE));
  assign capture = event_strobe && (state_q == MEASURE) && !freeze && !clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ARMED;
      ARMED: begin
        if (!enable)           state_d = IDLE;
        else if (event_strobe) state_d = MEASURE;
      end
      MEASURE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear wins over any event in the same cycle, including the arming one.
    if (clear) state_d = enable ? ARMED : IDLE;
  end

  always_comb begin
    ivl_d = ivl_q;
    if (clear)                                         ivl_d = 16'd0;
    else if (ev_seen)                                  ivl_d = 16'd1;
    else if ((state_q == MEASURE) && (ivl_q != 16'hFFFF)) ivl_d = ivl_q + 16'd1;
  end

  always_comb begin
    shifted = ivl_q >> SHIFT;
    bin_idx = shifted[IDX_W-1:0];
    if (shifted >= 16'(NUM_BINS)) bin_idx = IDX_W'(NUM_BINS - 1);
  end

  assign bin_cur  = bin_q[idx_q];
  assign bin_next = (&bin_cur) ? bin_cur : bin_cur + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ivl_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
    end
  end

  // Stage 1 latches the interval and its bin; stage 2 performs the increment.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cycle_cnt_q <= 16'd0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      event_cnt_q <= 16'd0;
      hist_sat_q  <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) bin_q[k] <= '0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        cycle_cnt_q <= ivl_q;
        idx_q       <= bin_idx;
      end
      if (valid_q) begin
        bin_q[idx_q] <= bin_next;
        if (&bin_next) hist_sat_q <= 1'b1;
        if (event_cnt_q != 16'hFFFF) event_cnt_q <= event_cnt_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_mon
    assign mon_cnts[g*CNT_SIZE +: CNT_SIZE] = bin_q[g];
  end

  assign cycle_cnt = cycle_cnt_q;
  assign event_cnt = event_cnt_q;
  assign hist_sat  = hist_sat_q;
  assign busy      = (state_q == MEASURE);

endmodule

`default_nettype wire

// File: tb/tb_interval_histogram_mon.sv
// Directed bench for interval_histogram_mon: default instance plus a CNT_SIZE=4
// instance for bin saturation.
`default_nettype none

module tb_interval_histogram_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, clear, freeze, ev;
  logic [15:0]  cycle_cnt, event_cnt;
  logic [255:0] mon_cnts;
  logic         hist_sat, busy;

  logic         enable2, clear2, freeze2, ev2;
  logic [15:0]  cycle_cnt2, event_cnt2;
  logic [63:0]  mon_cnts2;
  logic         hist_sat2, busy2;

  interval_histogram_mon dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .freeze(freeze),
    .event_strobe(ev), .cycle_cnt(cycle_cnt), .mon_cnts(mon_cnts),
    .event_cnt(event_cnt), .hist_sat(hist_sat), .busy(busy)
  );

  interval_histogram_mon #(.CNT_RANGE(8), .CNT_SIZE(4), .MAX_CYCLE_CNT(128)) dut4 (
    .clk(clk), .reset(reset), .enable(enable2), .clear(clear2), .freeze(freeze2),
    .event_strobe(ev2), .cycle_cnt(cycle_cnt2), .mon_cnts(mon_cnts2),
    .event_cnt(event_cnt2), .hist_sat(hist_sat2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;
  int exp_bins [16];
  int exp_evt;

  typedef struct {
    int          gap;
    logic [15:0] exp_cc;
    int          exp_bin;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    ev = 1'b1;
    tick();
    ev = 1'b0;
  endtask

  function automatic logic [255:0] pack_bins();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(exp_bins[k]);
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) exp_bins[k] = 0;
    exp_evt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{200, 16'd200, 15};
    tbl[1] = '{127, 16'd127, 15};
    tbl[2] = '{120, 16'd120, 15};
    tbl[3] = '{119, 16'd119, 14};
    tbl[4] = '{8,   16'd8,   1};
    tbl[5] = '{16,  16'd16,  2};
    tbl[6] = '{7,   16'd7,   0};
    tbl[7] = '{64,  16'd64,  8};

    reset = 1'b0; enable = 1'b0; clear = 1'b0; freeze = 1'b0; ev = 1'b0;
    enable2 = 1'b0; clear2 = 1'b0; freeze2 = 1'b0; ev2 = 1'b0;
    model_clear();
    idle(3);
    reset = 1'b1;
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_mon_cnts", mon_cnts, 0);
    chk("rst_event_cnt", event_cnt, 0);
    chk("rst_hist_sat", hist_sat, 0);
    chk("rst_busy", busy, 0);

    // Arm, then back-to-back event and a 9-cycle gap.
    enable = 1'b1;
    tick();
    pulse();
    chk("arm_busy", busy, 1);
    chk("arm_no_interval", cycle_cnt, 0);
    pulse();
    chk("b2b_cycle_cnt", cycle_cnt, 1);
    tick();
    exp_bins[0]++; exp_evt++;
    chk("b2b_mon", mon_cnts, pack_bins());
    chk("b2b_event_cnt", event_cnt, 16'(exp_evt));
    idle(7);
    pulse();
    chk("gap9_cycle_cnt", cycle_cnt, 9);
    tick();
    exp_bins[1]++; exp_evt++;
    chk("gap9_mon", mon_cnts, pack_bins());
    chk("gap9_event_cnt", event_cnt, 16'(exp_evt));

    for (int i = 0; i < 8; i++) begin
      idle(tbl[i].gap - 2);
      pulse();
      chk($sformatf("tbl%0d_cycle_cnt", i), cycle_cnt, tbl[i].exp_cc);
      tick();
      exp_bins[tbl[i].exp_bin]++; exp_evt++;
      chk($sformatf("tbl%0d_mon", i), mon_cnts, pack_bins());
      chk($sformatf("tbl%0d_event_cnt", i), event_cnt, 16'(exp_evt));
    end

    // Frozen events leave statistics alone but still restart the interval.
    freeze = 1'b1;
    idle(3);
    pulse();
    chk("frz_cycle_cnt", cycle_cnt, 64);
    tick();
    chk("frz_mon", mon_cnts, pack_bins());
    chk("frz_event_cnt", event_cnt, 16'(exp_evt));
    idle(3);
    pulse();
    tick();
    freeze = 1'b0;
    idle(5);
    pulse();
    chk("unfrz_cycle_cnt", cycle_cnt, 7);
    tick();
    exp_bins[0]++; exp_evt++;
    chk("unfrz_mon", mon_cnts, pack_bins());

    // Clear coincident with an event in MEASURE.
    ev = 1'b1; clear = 1'b1;
    tick();
    ev = 1'b0; clear = 1'b0;
    model_clear();
    chk("clr_mon", mon_cnts, 0);
    chk("clr_event_cnt", event_cnt, 0);
    chk("clr_cycle_cnt", cycle_cnt, 0);
    chk("clr_busy_armed", busy, 0);
    tick();
    chk("clr_no_late_event_cnt", event_cnt, 0);
    pulse();
    chk("clr_rearm_busy", busy, 1);
    chk("clr_rearm_no_interval", cycle_cnt, 0);
    idle(2);
    pulse();
    chk("clr_next_cycle_cnt", cycle_cnt, 3);
    tick();
    exp_bins[0]++; exp_evt++;
    chk("clr_next_mon", mon_cnts, pack_bins());
    chk("clr_next_event_cnt", event_cnt, 16'(exp_evt));

    // Reset one cycle after an event discards the pending update.
    pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_cycle_cnt", cycle_cnt, 0);
    chk("midrst_mon", mon_cnts, 0);
    chk("midrst_event_cnt", event_cnt, 0);
    chk("midrst_busy", busy, 0);
    tick();
    chk("midrst_no_late_mon", mon_cnts, 0);
    chk("midrst_no_late_event_cnt", event_cnt, 0);
    chk("dflt_hist_sat_clear", hist_sat, 0);

    // 4-bit bins: sixteen back-to-back intervals saturate bin 0.
    enable2 = 1'b1;
    tick();
    ev2 = 1'b1;
    tick();
    repeat (16) tick();
    ev2 = 1'b0;
    tick();
    tick();
    chk("sat_mon", mon_cnts2, 64'hF);
    chk("sat_hist_sat", hist_sat2, 1);
    chk("sat_event_cnt", event_cnt2, 16);
    chk("sat_cycle_cnt", cycle_cnt2, 1);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("satclr_mon", mon_cnts2, 0);
    chk("satclr_hist_sat", hist_sat2, 0);
    chk("satclr_event_cnt", event_cnt2, 0);
    chk("satclr_busy", busy2, 0);
    ev2 = 1'b1;
    tick();
    ev2 = 1'b0;
    chk("satclr_armed_busy", busy2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interval_histogram_mon.md
Name: interval_histogram_mon

Overview:
- Per-stream monitor that measures the number of clock cycles between consecutive event strobes, e.g. address-FIFO reads or vector-FIFO writes.
- Bins each measured interval into a saturating histogram.
- Its cycle_cnt and flattened mon_cnts outputs feed the driver control register block, which exposes them as a cycle count (16-bit) and a per-bin count array for software readback.
- One instance is used per monitored stream.

Parameters:
- CNT_RANGE, 8: interval width of one histogram bin, in cycles. Power of two, 1 or greater.
- CNT_SIZE, 16: width of each bin counter. Range 1..16.
- MAX_CYCLE_CNT, 128: interval span covered by the bins. Must be a multiple of CNT_RANGE. NUM_BINS = MAX_CYCLE_CNT/CNT_RANGE is a derived localparam, power of two, 2 or greater.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-low reset.
- enable, input, 1: monitoring enabled; driven by active_program.
- clear, input, 1: single-cycle strobe that zeroes all statistics.
- freeze, input, 1: holds the histogram and cycle_cnt.
- event_strobe, input, 1: one monitored event per high cycle.
- cycle_cnt, output, 16: last measured interval.
- mon_cnts, output, NUM_BINS*CNT_SIZE: bin k occupies bits [k*CNT_SIZE +: CNT_SIZE].
- event_cnt, output, 16: number of binned events, saturating.
- hist_sat, output, 1: sticky flag; set when any bin reaches its maximum.
- busy, output, 1: high while state is MEASURE.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. When reset is low at a clk edge, all registers are cleared. State goes to IDLE. cycle_cnt=0, every bin=0, event_cnt=0, hist_sat=0, busy=0, interval counter=0, update pipeline invalid. Reset mid-operation discards any pending update.
- States:
  - IDLE: go to ARMED when enable=1.
  - ARMED: go to MEASURE on event_strobe. No interval is produced for this first event.
  - MEASURE: each event_strobe produces one interval.
  - From ARMED or MEASURE, enable=0 returns to IDLE. Statistics are held.
- Interval counter (16-bit):
  - Loads 1 on the cycle after any event seen in ARMED or MEASURE.
  - Otherwise increments by 1 while in MEASURE, saturating at 16'hFFFF.
  - Result: back-to-back events give interval=1. Events spaced N cycles apart give interval=N.
- Stage 1 (event cycle T, in MEASURE, freeze=0): capture the interval.
  - cycle_cnt takes the interval at T+1.
  - bin index = min(interval/CNT_RANGE, NUM_BINS-1) is computed by shift. Intervals of MAX_CYCLE_CNT or more go to the last bin.
- Stage 2 (T+2):
  - Selected bin increments by 1, saturating at 2^CNT_SIZE-1.
  - When the bin reaches its maximum, hist_sat is set and stays set until clear or reset.
  - event_cnt increments at T+2, saturating at 16'hFFFF.
- Freeze:
  - With freeze=1 on the event cycle, the interval is discarded: no cycle_cnt, bin or event_cnt update.
  - The interval counter still restarts, so timing stays accurate.
  - An update already in stage 1 when freeze rises still completes.
- Enable falling: an update already in the pipeline completes.
- Clear:
  - On the next edge, all bins, cycle_cnt, event_cnt and hist_sat are zeroed, and the pipeline valid is dropped.
  - State goes to ARMED if enable=1, else IDLE. The interval counter is zeroed.
  - Clear has priority over a simultaneous event or pending update. That event is neither binned nor used to arm.
- Outputs are registered with no combinational input-to-output path. mon_cnts is driven directly from the bin registers.
- Only one bin changes per cycle, so there are no multi-port hazards. Events every cycle are sustained at full rate.

Test Plan:
- Reset, enable=1, events at cycles 10, 11, 20 -> cycle_cnt=1 at cycle 12, bin0=1 at cycle 13. Then cycle_cnt=9 at cycle 21, bin1=1 at cycle 22, event_cnt=2.
- Events 200 cycles apart (default parameters) -> cycle_cnt=200, bin15 increments. An interval of exactly 127 also lands in bin15. An interval of 120 lands in bin15; 119 lands in bin14.
- CNT_SIZE=4, 16 back-to-back events after arming -> bin0=15, hist_sat=1, event_cnt=16. clear -> all zero, hist_sat=0, state ARMED.
- freeze=1 during events 5 cycles apart, then freeze=0 and the next event 7 cycles later -> histogram unchanged while frozen, then cycle_cnt=7 and bin0 increments.
- clear asserted in the same cycle as an event in MEASURE -> no bin update, event_cnt=0. The next event only arms; the interval is measured from it.
- reset low one cycle after an event -> all outputs 0 two cycles later, and no late bin increment appears.
